bin_gray_conv_ques3: RTL and testbench



---
 rtl/gray_pkg.sv | 23 ++
 rtl/gray2bin_conv.sv | 13 +
 rtl/bin_gray_conv_ques3.sv | 56 +++++
 tb/tb_bin_gray_conv_ques3.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: conversion functions written for 32 bits and
// sliced by callers to their own width.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs keep the upper bits 0, so the prefix XOR can always
  // start at bit 31 regardless of the caller's width.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary reconstruction (prefix XOR from the MSB).
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(gray2bin(MAX_WIDTH'(i_gray)));

endmodule

// File: rtl/bin_gray_conv_ques3.sv
// Binary-to-Gray converter with a combinational output, a valid-qualified
// registered copy, and a sticky round-trip corruption flag.
module bin_gray_conv_ques3
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] g_q,
  output logic             g_vld,
  output logic [WIDTH-1:0] b_rt,
  output logic             rt_err
);

  logic [WIDTH-1:0] r_g_q;
  logic [WIDTH-1:0] r_b_cap;
  logic             r_g_vld;
  logic             r_rt_err;
  logic [WIDTH-1:0] w_b_rt;

  assign g = WIDTH'(bin2gray(MAX_WIDTH'(b)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; rst is checked first so it wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_q    <= '0;
      r_b_cap  <= '0;
      r_g_vld  <= 1'b0;
      r_rt_err <= 1'b0;
    end else begin
      if (in_valid) begin
        r_g_q   <= WIDTH'(bin2gray(MAX_WIDTH'(b)));
        r_b_cap <= b;
      end
      r_g_vld  <= in_valid;
      // Sticky: once a mismatch is seen it stays set until reset.
      r_rt_err <= r_rt_err | (r_g_vld & (w_b_rt != r_b_cap));
    end
  end

  gray2bin_conv #(.WIDTH(WIDTH)) u_gray2bin (
    .i_gray (r_g_q),
    .o_bin  (w_b_rt)
  );

  assign g_q    = r_g_q;
  assign g_vld  = r_g_vld;
  assign b_rt   = w_b_rt;
  assign rt_err = r_rt_err;

endmodule

// File: tb/tb_bin_gray_conv_ques3.sv
// Self-checking bench: constant Gray table, observed adjacency, scoreboarded
// registered path, reset priority, forced-corruption and WIDTH=8 checks.
module tb_bin_gray_conv_ques3;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] b;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b;
  logic       in_valid;
  logic [3:0] g, g_q, b_rt;
  logic       g_vld, rt_err;

  logic [7:0] b8;
  logic       in_valid8;
  logic [7:0] g8, g_q8, b_rt8;
  logic       g_vld8, rt_err8;

  int pass_cnt = 0;
  int total_cnt = 0;

  vec_t       tab [16];
  logic [3:0] g_obs [16];
  sb_t        sb_q [$];

  always #5 clk = ~clk;

  bin_gray_conv_ques3 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .b(b), .in_valid(in_valid),
    .g(g), .g_q(g_q), .g_vld(g_vld), .b_rt(b_rt), .rt_err(rt_err)
  );

  bin_gray_conv_ques3 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .b(b8), .in_valid(in_valid8),
    .g(g8), .g_q(g_q8), .g_vld(g_vld8), .b_rt(b_rt8), .rt_err(rt_err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] gray_codes [16];
    sb_t         exp;
    gray_codes = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    for (int i = 0; i < 16; i++) begin
      tab[i].b = 4'(i);
      tab[i].g = gray_codes[i][3:0];
    end

    rst = 1'b1; b = '0; in_valid = 1'b0; b8 = '0; in_valid8 = 1'b0;
    tick(); tick();
    check("reset_g_q", 32'(g_q), 32'h0);
    check("reset_g_vld", 32'(g_vld), 32'h0);
    check("reset_rt_err", 32'(rt_err), 32'h0);
    check("reset_b_rt", 32'(b_rt), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // Combinational sweep with a 5 ns settle per value.
    for (int i = 0; i < 16; i++) begin
      b = tab[i].b;
      #5;
      g_obs[i] = g;
      check($sformatf("comb_g_b%0d", i), 32'(g), 32'(tab[i].g));
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("adjacent_%0d", i),
            32'($countones(g_obs[i] ^ g_obs[(i + 1) % 16])), 32'd1);
    end

    // Capture then hold.
    @(negedge clk);
    b = 4'b0110; in_valid = 1'b1;
    tick();
    check("cap_g_q", 32'(g_q), 32'h5);
    check("cap_g_vld", 32'(g_vld), 32'h1);
    check("cap_b_rt", 32'(b_rt), 32'h6);
    @(negedge clk);
    in_valid = 1'b0; b = 4'b1001;
    tick();
    check("hold_g_vld", 32'(g_vld), 32'h0);
    check("hold_g_q", 32'(g_q), 32'h5);

    // Scoreboarded random burst, including back-to-back captures.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      b = 4'($urandom_range(0, 15));
      in_valid = (k < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      if (in_valid) sb_q.push_back('{g: tab[b].g, b: b});
      tick();
      check("burst_g_vld", 32'(g_vld), 32'(in_valid));
      if (g_vld) begin
        if (sb_q.size() == 0) begin
          check("burst_sb_empty", 32'h1, 32'h0);
        end else begin
          exp = sb_q.pop_front();
          check("burst_g_q", 32'(g_q), 32'(exp.g));
          check("burst_b_rt", 32'(b_rt), 32'(exp.b));
        end
      end
      check("burst_rt_err", 32'(rt_err), 32'h0);
    end
    check("burst_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset wins over a same-edge capture; g keeps tracking b.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; b = 4'b1111;
    tick();
    check("rstpri_g_q", 32'(g_q), 32'h0);
    check("rstpri_g_vld", 32'(g_vld), 32'h0);
    check("rstpri_rt_err", 32'(rt_err), 32'h0);
    check("rstpri_g", 32'(g), 32'h8);

    // Corrupt the captured binary value behind a valid capture.
    @(negedge clk);
    rst = 1'b0; b = 4'b0110; in_valid = 1'b1;
    tick();
    check("fault_pre_g_q", 32'(g_q), 32'h5);
    check("fault_pre_rt_err", 32'(rt_err), 32'h0);
    force dut.r_b_cap = 4'b0000;
    in_valid = 1'b0;
    tick();
    check("fault_rt_err", 32'(rt_err), 32'h1);
    release dut.r_b_cap;
    tick(); tick(); tick();
    check("fault_sticky", 32'(rt_err), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("fault_cleared", 32'(rt_err), 32'h0);

    // WIDTH=8 instance.
    @(negedge clk);
    rst = 1'b0;
    b8 = 8'hFF; #1;
    check("w8_g_ff", 32'(g8), 32'h80);
    b8 = 8'h80; #1;
    check("w8_g_80", 32'(g8), 32'hC0);
    @(negedge clk);
    b8 = 8'hA5; in_valid8 = 1'b1;
    tick();
    check("w8_g_q", 32'(g_q8), 32'hF7);
    check("w8_b_rt", 32'(b_rt8), 32'hA5);
    check("w8_g_vld", 32'(g_vld8), 32'h1);
    @(negedge clk);
    in_valid8 = 1'b0;
    tick();
    check("w8_rt_err", 32'(rt_err8), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
